// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - EX-stage request/result bundle for seq_alu
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] busA;
   logic [WIDTH-1:0] busB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, busA, busB,
      input  busy, done, result, zero, hi, lo
   );

   modport slave (
      input  start, op, busA, busB,
      output busy, done, result, zero, hi, lo
   );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU, iterative MULT/DIV into HI/LO; divider built only with SEQ_ALU_DIV_EN
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic      clk,
   input logic      rst,
   seq_alu_if.slave bus
);
   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_SLT   = 4'h4;
   localparam logic [3:0] OP_SLTU  = 4'h5;
   localparam logic [3:0] OP_XOR   = 4'h6;
   localparam logic [3:0] OP_NOR   = 4'h7;
   localparam logic [3:0] OP_SLL   = 4'h8;
   localparam logic [3:0] OP_SRL   = 4'h9;
   localparam logic [3:0] OP_SRA   = 4'hA;
   localparam logic [3:0] OP_MULT  = 4'hB;
   localparam logic [3:0] OP_MULTU = 4'hC;
   localparam logic [3:0] OP_DIV   = 4'hD;
   localparam logic [3:0] OP_DIVU  = 4'hE;
   localparam logic [3:0] OP_MFHI  = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   // Accepted request waiting one cycle before execution
   logic             req_q, req_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   // Iteration registers: acc = product high half / partial remainder,
   // wrk = multiplier / dividend-then-quotient, m = multiplicand / divisor
   logic [WIDTH-1:0] acc_q, acc_d, wrk_q, wrk_d, m_q, m_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             neg_q, neg_d;
`ifdef SEQ_ALU_DIV_EN
   logic             div_q, div_d, rneg_q, rneg_d;
`endif
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d;
   logic             zero_q, zero_d, done_q, done_d;

   logic             is_mult, is_div, is_signed, go_iter, accept;
   logic [WIDTH-1:0] mag_a, mag_b, alu_res;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   mul_sum;
   logic [2*WIDTH-1:0] prod, prod_neg;

   assign is_mult   = (op_q == OP_MULT) || (op_q == OP_MULTU);
`ifdef SEQ_ALU_DIV_EN
   assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
`else
   assign is_div    = 1'b0;
`endif
   assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
   assign go_iter   = req_q && (is_mult || (is_div && (b_q != '0)));
   // A pending iterative request blocks the slot even though busy is still low
   assign accept    = bus.start && (state_q == S_IDLE) && !go_iter;
   assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
   assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
   assign shamt     = b_q[SHW-1:0];
   assign mul_sum   = {1'b0, acc_q} + {1'b0, (wrk_q[0] ? m_q : {WIDTH{1'b0}})};
   assign prod      = {acc_q, wrk_q};
   assign prod_neg  = -prod;

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   assign div_shift = {acc_q, wrk_q[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, m_q};
`endif

   // Single-cycle result for the pending request
   always_comb begin
      alu_res = '0;
      case (op_q)
         OP_ADD:  alu_res = a_q + b_q;
         OP_SUB:  alu_res = a_q - b_q;
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_NOR:  alu_res = ~(a_q | b_q);
         OP_SLL:  alu_res = a_q << shamt;
         OP_SRL:  alu_res = a_q >> shamt;
         OP_SRA:  alu_res = $signed(a_q) >>> shamt;
         OP_MFHI: alu_res = hi_q;
`ifdef SEQ_ALU_DIV_EN
         OP_DIV, OP_DIVU: alu_res = '1;
`endif
         default: alu_res = '0;
      endcase
   end

   // Next-state, iteration step and result write-back
   always_comb begin
      state_d = state_q;
      req_d   = accept;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      wrk_d   = wrk_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
`ifdef SEQ_ALU_DIV_EN
      div_d   = div_q;
      rneg_d  = rneg_q;
`endif
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      if (accept) begin
         op_d = bus.op;
         a_d  = bus.busA;
         b_d  = bus.busB;
      end
      case (state_q)
         S_IDLE: begin
            if (go_iter) begin
               state_d = S_ITER;
               cnt_d   = '0;
               acc_d   = '0;
               neg_d   = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               wrk_d   = mag_b;
               m_d     = mag_a;
`ifdef SEQ_ALU_DIV_EN
               div_d   = is_div;
               rneg_d  = is_signed && a_q[WIDTH-1];
               if (is_div) begin
                  wrk_d = mag_a;
                  m_d   = mag_b;
               end
`endif
            end else if (req_q) begin
               res_d  = alu_res;
               zero_d = (alu_res == '0);
               done_d = 1'b1;
`ifdef SEQ_ALU_DIV_EN
               // Only a zero divisor reaches here for DIV/DIVU
               if (is_div) begin
                  hi_d = a_q;
                  lo_d = '1;
               end
`endif
            end
         end
         S_ITER: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = S_FIN;
            acc_d = mul_sum[WIDTH:1];
            wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
            if (div_q) begin
               if (!div_diff[WIDTH+1]) begin
                  acc_d = div_diff[WIDTH-1:0];
                  wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = div_shift[WIDTH-1:0];
                  wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
               end
            end
`endif
         end
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            hi_d    = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
            lo_d    = neg_q ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
`ifdef SEQ_ALU_DIV_EN
            if (div_q) begin
               lo_d = neg_q ? -wrk_q : wrk_q;
               hi_d = rneg_q ? -acc_q : acc_q;
            end
`endif
            res_d  = lo_d;
            zero_d = (lo_d == '0);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any op in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         wrk_q   <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
         div_q   <= 1'b0;
         rneg_q  <= 1'b0;
`endif
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         wrk_q   <= wrk_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
`ifdef SEQ_ALU_DIV_EN
         div_q   <= div_d;
         rneg_q  <= rneg_d;
`endif
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = done_q;
   assign bus.result = res_q;
   assign bus.zero   = zero_q;
   assign bus.hi     = hi_q;
   assign bus.lo     = lo_q;
endmodule
